// File: rtl/ahb_regbank.sv
// ============================================================================
//  Module   : ahb_regbank
//  Purpose  : AHB data-phase bank of NUM_REGS 64-bit control registers with
//             byte-lane writes, combinational read data and an optional
//             two-cycle ERROR response (compiled in by AHB_REGBANK_ERR_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_regbank #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hsel,
    input  logic                     hwrite,
    input  logic [1:0]               htrans,
    input  logic [2:0]               hsize,
    input  logic [31:0]              haddr,
    input  logic [7:0]               wr_en,
    input  logic [63:0]              hwdata,
    output logic [63:0]              hrdata,
    output logic                     hreadyout,
    output logic                     hresp,
    output logic [NUM_REGS*64-1:0]   regs,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam logic [9:0] NUM_REGS_W = 10'(NUM_REGS);

    logic        active;
    logic        in_win;
    logic        mapped;
    logic        bad;
    logic        in_idle;
    logic        commit;
    logic        rd_hit;
    logic [8:0]  idx;
    logic [63:0] rd_word;

    // Size and the low address bits are already folded into wr_en upstream.
    wire unused_inputs = &{1'b0, htrans[0], hsize, haddr[2:0]};

    assign active = hsel & htrans[1];
    assign in_win = (haddr[31:12] == BASE_ADDR[31:12]);
    assign idx    = haddr[11:3];
    assign mapped = in_win & ({1'b0, idx} < NUM_REGS_W);
    assign bad    = active & (~mapped | (wr_en == 8'h00));
    assign commit = active & hwrite & ~bad & in_idle;

`ifdef AHB_REGBANK_ERR_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ERR2 = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   ready_c;
    logic   resp_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In ERR2 the upstream stage still holds the bad transfer; it is ignored.
    always_comb begin
        state_next = state;
        ready_c    = 1'b1;
        resp_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bad) begin
                    ready_c    = 1'b0;
                    resp_c     = 1'b1;
                    state_next = S_ERR2;
                end
            end
            S_ERR2: begin
                ready_c    = 1'b1;
                resp_c     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign in_idle   = (state == S_IDLE);
    // Reset forces the bus response even while inputs still show a bad transfer.
    assign hreadyout = ~rst_n | ready_c;
    assign hresp     = rst_n & resp_c;
    assign rd_hit    = active & ~hwrite & mapped;
`else
    assign in_idle   = 1'b1;
    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;
    assign rd_hit    = active & ~hwrite & mapped & (wr_en != 8'h00);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs     <= '0;
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse[i] <= commit && (idx == 9'(i));
                for (int k = 0; k < 8; k++) begin
                    if (commit && (idx == 9'(i)) && wr_en[k]) begin
                        regs[64*i + 8*k +: 8] <= hwdata[8*k +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = 64'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 9'(i)) begin
                rd_word = regs[64*i +: 64];
            end
        end
    end

    assign hrdata = (rst_n && rd_hit) ? rd_word : 64'h0;

endmodule

`default_nettype wire
